// File: rtl/paral_serial_8bits.sv
// MSB-first 8:1 serializer on clk_32f: words load on bit_cnt==0, first bit appears 1 edge after load.
// No backpressure: data_in/valid_in are sampled only on load edges; otherwise the idle symbol is sent.
module paral_serial_8bits #(
  parameter logic [7:0] IDLE_SYMBOL = 8'hBC,
  parameter int         SYNC_WORDS  = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       load_ready,
  output logic       active
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS - 1);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [3:0] sync_cnt;
  logic [7:0] word;

  assign load_ready = (bit_cnt == 3'd0);

  // Inputs are ignored until the receiver has seen the full idle run.
  always_comb begin
    word = IDLE_SYMBOL;
    if (state == ACTIVE && valid_in) word = data_in;
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      data_out <= 1'b0;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      sync_cnt <= 4'd0;
      state    <= SYNC;
      active   <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (load_ready) begin
        data_out <= word[7];
        shreg    <= {word[6:0], 1'b0};
        if (state == SYNC) begin
          if (sync_cnt == SYNC_LAST) begin
            state  <= ACTIVE;
            active <= 1'b1;
          end else begin
            sync_cnt <= sync_cnt + 4'd1;
          end
        end
      end else begin
        data_out <= shreg[7];
        shreg    <= {shreg[6:0], 1'b0};
      end
    end
  end

endmodule
